// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: pixel-rate divider, DrawX/DrawY counters, sync/blank strobes.
// Optional VGA_FRAME_COUNT_EN adds a 16-bit frame counter output (frame_cnt).
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        Clk,
  input  logic        Reset,
`ifdef VGA_FRAME_COUNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        VGA_CLK,
  output logic        pix_en,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic       r_tick;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank_n;
  logic       r_line_start;
  logic       r_frame_start;

  logic       w_x_end;
  logic       w_y_end;
  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;

  assign w_x_end = (r_x == H_LAST);
  assign w_y_end = (r_y == V_LAST);

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (r_tick) begin
      if (w_x_end) begin
        w_x_nxt = '0;
        w_y_nxt = w_y_end ? '0 : r_y + 10'd1;
      end else begin
        w_x_nxt = r_x + 10'd1;
      end
    end
  end

  // Strobes are derived from the next coordinates so they switch on the same edge as DrawX/DrawY.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_tick        <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank_n     <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_tick        <= ~r_tick;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_hs          <= ~((w_x_nxt >= H_SYNC_BEG) && (w_x_nxt < H_SYNC_END));
      r_vs          <= ~((w_y_nxt >= V_SYNC_BEG) && (w_y_nxt < V_SYNC_END));
      r_blank_n     <= (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
      r_line_start  <= r_tick && w_x_end;
      r_frame_start <= r_tick && w_x_end && w_y_end;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_cnt <= '0;
    end else if (r_tick && w_x_end && w_y_end) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign VGA_CLK     = r_tick;
  assign pix_en      = r_tick;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance plus a scaled-down instance for whole-frame checks,
// both compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pen;
    logic        hs;
    logic        vs;
    logic        bn;
    logic        ls;
    logic        fs;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_d, rst_s;

  logic       d_vclk, d_pen, d_hs, d_vs, d_bn, d_sn, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_vclk, s_pen, s_hs, s_vs, s_bn, s_sn, s_ls, s_fs;
  logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] d_fc, s_fc;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int unsigned n_d = 0;
  int unsigned n_s = 0;

  always #10 clk = ~clk;

  vga_timing_gen u_def (
    .Clk(clk), .Reset(rst_d),
`ifdef VGA_FRAME_COUNT_EN
    .frame_cnt(d_fc),
`endif
    .VGA_CLK(d_vclk), .pix_en(d_pen), .VGA_HS(d_hs), .VGA_VS(d_vs),
    .VGA_BLANK_N(d_bn), .VGA_SYNC_N(d_sn), .DrawX(d_x), .DrawY(d_y),
    .line_start(d_ls), .frame_start(d_fs)
  );

  // 15 x 11 raster, 330 Clk per frame
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1)
  ) u_small (
    .Clk(clk), .Reset(rst_s),
`ifdef VGA_FRAME_COUNT_EN
    .frame_cnt(s_fc),
`endif
    .VGA_CLK(s_vclk), .pix_en(s_pen), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn), .DrawX(s_x), .DrawY(s_y),
    .line_start(s_ls), .frame_start(s_fs)
  );

  // n = Clk edges since the last edge that sampled reset
  always @(posedge clk) begin
    n_d <= rst_d ? 0 : n_d + 1;
    n_s <= rst_s ? 0 : n_s + 1;
  end

  function automatic exp_t model(int unsigned n, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb);
    exp_t        e;
    int          ht;
    int          vt;
    int unsigned p;
    int          x;
    int          y;
    logic        adv;
    ht   = hv + hf + hsw + hb;
    vt   = vv + vf + vsw + vb;
    p    = n / 2;
    x    = int'(p % ht);
    y    = int'((p / ht) % vt);
    adv  = (n > 0) && (n[0] == 1'b0);
    e.pen = n[0];
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.hs  = !((x >= hv + hf) && (x < hv + hf + hsw));
    e.vs  = !((y >= vv + vf) && (y < vv + vf + vsw));
    e.bn  = (x < hv) && (y < vv);
    e.ls  = adv && (x == 0);
    e.fs  = adv && (x == 0) && (y == 0);
    e.fc  = 16'(p / (ht * vt));
    return e;
  endfunction

  task automatic chk(string name, logic [15:0] obs, logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", name, obs, expv, cyc);
    end
  endtask

  task automatic check_all();
    exp_t e;
    e = model(n_d, 640, 16, 96, 48, 480, 10, 2, 33);
    chk("def_x", 16'(d_x), 16'(e.x));
    chk("def_y", 16'(d_y), 16'(e.y));
    chk("def_pix_en", 16'(d_pen), 16'(e.pen));
    chk("def_vga_clk", 16'(d_vclk), 16'(e.pen));
    chk("def_hs", 16'(d_hs), 16'(e.hs));
    chk("def_vs", 16'(d_vs), 16'(e.vs));
    chk("def_blank_n", 16'(d_bn), 16'(e.bn));
    chk("def_sync_n", 16'(d_sn), 16'd0);
    chk("def_line_start", 16'(d_ls), 16'(e.ls));
    chk("def_frame_start", 16'(d_fs), 16'(e.fs));
`ifdef VGA_FRAME_COUNT_EN
    chk("def_frame_cnt", d_fc, e.fc);
`endif
    e = model(n_s, 8, 2, 3, 2, 6, 2, 2, 1);
    chk("sm_x", 16'(s_x), 16'(e.x));
    chk("sm_y", 16'(s_y), 16'(e.y));
    chk("sm_pix_en", 16'(s_pen), 16'(e.pen));
    chk("sm_vga_clk", 16'(s_vclk), 16'(e.pen));
    chk("sm_hs", 16'(s_hs), 16'(e.hs));
    chk("sm_vs", 16'(s_vs), 16'(e.vs));
    chk("sm_blank_n", 16'(s_bn), 16'(e.bn));
    chk("sm_sync_n", 16'(s_sn), 16'd0);
    chk("sm_line_start", 16'(s_ls), 16'(e.ls));
    chk("sm_frame_start", 16'(s_fs), 16'(e.fs));
`ifdef VGA_FRAME_COUNT_EN
    chk("sm_frame_cnt", s_fc, e.fc);
`endif
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  initial begin
    int   xs [6];
    int   hs_low;
    int   bn_low;
    int   ls_cnt;
    int   vs_low;
    int   ls_t [$];
    int   fs_t [$];
    logic found;

    xs = '{0, 0, 1, 1, 2, 2};
    hs_low = 0; bn_low = 0; ls_cnt = 0; vs_low = 0; found = 1'b0;

    // reset held 5 cycles, then released
    rst_d = 1'b1;
    rst_s = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_d = 1'b0;
    rst_s = 1'b0;
    check_all();
    chk("rst_hs", 16'(d_hs), 16'd1);
    chk("rst_vs", 16'(d_vs), 16'd1);
    chk("rst_blank_n", 16'(d_bn), 16'd1);
    chk("rst_pulses", 16'({d_ls, d_fs}), 16'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      chk("x_seq", 16'(d_x), 16'(xs[i]));
      chk("pix_en_seq", 16'(d_pen), 16'(i % 2));
    end

    // first two lines of the default raster
    for (int i = 0; i < 3300; i++) begin
      step();
      if (d_y == 10'd0 && !d_hs) hs_low++;
      if (d_y == 10'd0 && !d_bn) bn_low++;
      if (d_ls) ls_t.push_back(cyc);
    end
    chk("hs_low_clks", 16'(hs_low), 16'd192);
    chk("blank_low_clks", 16'(bn_low), 16'd320);
    if (ls_t.size() >= 2) chk("line_period", 16'(ls_t[1] - ls_t[0]), 16'd1600);
    else chk("line_pulses_seen", 16'(ls_t.size()), 16'd2);

    // whole frames on the scaled raster
    for (int i = 0; i < 1400; i++) begin
      step();
      if (s_fs) begin
        fs_t.push_back(cyc);
        chk("fs_with_ls", 16'(s_ls), 16'd1);
        chk("fs_x0", 16'(s_x), 16'd0);
        chk("fs_y0", 16'(s_y), 16'd0);
      end
      if (fs_t.size() == 1) begin
        if (s_ls) ls_cnt++;
        if (!s_vs) vs_low++;
      end
    end
    if (fs_t.size() >= 3) begin
      chk("frame_period_a", 16'(fs_t[1] - fs_t[0]), 16'd330);
      chk("frame_period_b", 16'(fs_t[2] - fs_t[1]), 16'd330);
    end else chk("frame_pulses_seen", 16'(fs_t.size()), 16'd3);
    chk("lines_per_frame", 16'(ls_cnt), 16'd11);
    chk("vs_low_clks", 16'(vs_low), 16'd60);

    // reset for one Clk inside both sync windows
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (s_x == 10'd11 && s_y == 10'd8) found = 1'b1;
    end
    chk("mid_reset_reached", 16'(found), 16'd1);
    chk("mid_hs_low", 16'(s_hs), 16'd0);
    chk("mid_vs_low", 16'(s_vs), 16'd0);
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    chk("post_rst_x", 16'(s_x), 16'd0);
    chk("post_rst_y", 16'(s_y), 16'd0);
    chk("post_rst_hs", 16'(s_hs), 16'd1);
    chk("post_rst_vs", 16'(s_vs), 16'd1);
    chk("post_rst_blank_n", 16'(s_bn), 16'd1);
    chk("post_rst_fs", 16'(s_fs), 16'd0);
    chk("post_rst_pen", 16'(s_pen), 16'd0);
    step();
    chk("restart_pen", 16'(s_pen), 16'd1);
    chk("restart_x", 16'(s_x), 16'd0);
    step();
    chk("restart_x1", 16'(s_x), 16'd1);

    // random run lengths with random reset pulses on either instance
    for (int k = 0; k < 15; k++) begin
      int len;
      len = int'($urandom_range(40, 300));
      for (int i = 0; i < len; i++) step();
      if ($urandom_range(0, 1) == 1) rst_s = 1'b1;
      else rst_d = 1'b1;
      len = int'($urandom_range(1, 3));
      for (int i = 0; i < len; i++) step();
      rst_s = 1'b0;
      rst_d = 1'b0;
    end

    // uninterrupted stretch covering several scaled frames
    for (int i = 0; i < 1100; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
